mem_portb_arbiter: RTL
======================

Name: mem_portb_arbiter

Overview:
- Shares the data-memory port B (RAM plus MMIO decode) between two requesters: the CPU load/store unit and the UART program loader.
- Registers the winning request onto the port and returns read data with fixed latency.
- Arbitration is fixed-priority CPU, with a loader burst lock and a starvation guard.
- Sits between the MEM stage / loader and the memory block's port B (addrb, write_datab, web, datab).

Parameters:
- DATA_W, 32, width of address, write data and read data.
- STARVE_MAX, 8, consecutive denied CPU request cycles before the CPU wins unconditionally (range 1..255).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  DATA_W  CPU byte address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU request issued (1-cycle pulse).
- cpu_rvalid  out  1  CPU response valid (1-cycle pulse).
- cpu_rdata  out  DATA_W  CPU read data.
- ldr_req  in  1  loader access request.
- ldr_we  in  1  loader write / read.
- ldr_lock  in  1  loader burst lock.
- ldr_addr  in  DATA_W  loader byte address.
- ldr_wdata  in  DATA_W  loader write data.
- ldr_gnt  out  1  loader request issued.
- ldr_rvalid  out  1  loader response valid.
- ldr_rdata  out  DATA_W  loader read data.
- ldr_err  out  1  loader access rejected (see Optional Feature).
- mem_addr  out  DATA_W  to port B address.
- mem_wdata  out  DATA_W  to port B write data.
- mem_we  out  1  to port B write enable.
- mem_rdata  in  DATA_W  from port B read data.

Behaviour:
- Reset: all outputs are 0; FSM goes to S_IDLE; the starvation counter is 0.
- Reset mid-operation discards any issued-but-unreturned response; no rvalid fires after reset release for pre-reset accesses.

Handshake:
- req/we/addr/wdata are sampled every cycle.
- The requester holds them stable until it sees gnt.
- In the cycle gnt is high, the requester's inputs are treated as a new request.

Pipeline (winner decided in cycle N):
- Posedge ending N: mem_addr, mem_wdata and mem_we are loaded from the winner's fields.
- Cycle N+1: gnt_x = 1.
- If no winner in N: mem_we = 0 in N+1 and mem_addr/mem_wdata hold their values.
- mem_rdata is sampled at the end of N+1.
- Cycle N+2: rvalid_x = 1 with rdata_x, for both reads and writes (write rdata is don't-care).
- rdata_x holds its value until the next rvalid_x.
- Throughput is one access per cycle; the two response streams never overlap in the same cycle.

FSM (state = owner of the last issued access):
- S_IDLE, S_CPU, S_LDR, S_LDR_BURST.
- Default: the CPU wins if cpu_req.
- In S_LDR_BURST: the loader wins if ldr_req, even if cpu_req.
- Entry to S_LDR_BURST: loader issue while ldr_lock = 1.
- Exit from S_LDR_BURST: ldr_lock = 0, or a cycle with no ldr_req. Next state is S_CPU if the CPU issues, S_LDR if the loader issues, else S_IDLE.

Starvation counter:
- Increments each cycle cpu_req = 1 and the CPU loses; saturates at STARVE_MAX.
- Clears on a CPU issue or when cpu_req = 0.
- At STARVE_MAX the CPU wins regardless of state.

Simultaneous events and boundaries:
- No requests: S_IDLE and no issue.
- Both requesters may receive gnt in consecutive cycles but never in the same cycle.

Optional Feature:
- Macro: MMIO_PROTECT_EN.
- When defined:
  - A loader request with ldr_addr[31:16] == 16'hFFFF is accepted (ldr_gnt pulses on the normal schedule) but not driven to the port: mem_we = 0 that cycle.
  - ldr_rvalid and ldr_err both pulse in N+2, with ldr_rdata = 0.
  - CPU MMIO accesses are unaffected.
- When undefined: all loader addresses pass through and ldr_err is tied 0.

Test Plan:
- Single CPU read: cpu_req=1, cpu_addr=0x0000_0010, mem_rdata=0xDEAD_BEEF. Required: mem_addr=0x10 and cpu_gnt=1 in cycle 1; cpu_rvalid=1 and cpu_rdata=0xDEAD_BEEF in cycle 2.
- Contention without lock: both requesters active, loader write 0x0000_0100 ← 0x1234. Required: CPU granted first; loader granted the cycle after the CPU drops its request; mem_we=1 only in the loader's gnt cycle.
- Burst lock: ldr_lock=1 with 4 back-to-back loader writes at 0x0, 0x4, 0x8, 0xC while the CPU requests from the second write onward. Required: all 4 loader gnts are consecutive, then cpu_gnt.
- Starvation, STARVE_MAX=3: ldr_lock=1 and ldr_req held continuously, cpu_req held. Required: cpu_gnt after exactly 3 denied cycles; the loader resumes afterwards.
- Async reset: assert rst_n=0 the cycle after a CPU issue. Required: all outputs 0 immediately; no cpu_rvalid after release.
- MMIO_PROTECT_EN defined: loader write to 0xFFFF_FF0C. Required: ldr_gnt=1, mem_we=0, then ldr_rvalid=1 and ldr_err=1. Without the macro: mem_we=1 and ldr_err=0.

Source files
------------

// File: rtl/mem_portb_arbiter.sv
// mem_portb_arbiter: shares data-memory port B between the CPU and the UART loader.
// Optional MMIO_PROTECT_EN rejects loader accesses to the 0xFFFF_xxxx MMIO window.
module mem_portb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic              ldr_lock,
    input  logic [DATA_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_err,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_CPU, S_LDR, S_LDR_BURST} state_t;

    localparam logic [7:0] SMAX = 8'(STARVE_MAX);

    state_t     state, state_nxt;
    logic [7:0] starve_cnt, starve_nxt;
    logic       cpu_win, ldr_win, ldr_prot, err_q;

`ifdef MMIO_PROTECT_EN
    assign ldr_prot = ldr_addr[DATA_W-1 -: 16] == 16'hFFFF;
`else
    assign ldr_prot = 1'b0;
`endif

    // Burst priority only holds while the loader keeps both req and lock up.
    always_comb begin
        cpu_win    = cpu_req && (starve_cnt == SMAX ||
                     !(state == S_LDR_BURST && ldr_req && ldr_lock));
        ldr_win    = ldr_req && !cpu_win;
        state_nxt  = cpu_win ? S_CPU : ldr_win ? (ldr_lock ? S_LDR_BURST : S_LDR) : S_IDLE;
        starve_nxt = (!cpu_req || cpu_win) ? 8'd0 :
                     (starve_cnt == SMAX) ? starve_cnt : starve_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            starve_cnt <= 8'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_gnt    <= 1'b0;
            ldr_gnt    <= 1'b0;
            err_q      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rvalid <= 1'b0;
            ldr_rvalid <= 1'b0;
            ldr_err    <= 1'b0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
        end else begin
            cpu_gnt    <= cpu_win;
            ldr_gnt    <= ldr_win;
            err_q      <= ldr_win && ldr_prot;
            mem_we     <= cpu_win ? cpu_we : (ldr_win && !ldr_prot && ldr_we);
            if (cpu_win) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (ldr_win && !ldr_prot) begin
                mem_addr  <= ldr_addr;
                mem_wdata <= ldr_wdata;
            end
            cpu_rvalid <= cpu_gnt;
            ldr_rvalid <= ldr_gnt;
            ldr_err    <= ldr_gnt && err_q;
            if (cpu_gnt) cpu_rdata <= mem_rdata;
            if (ldr_gnt) ldr_rdata <= err_q ? '0 : mem_rdata;
        end
    end
endmodule
